// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/response stage: multiply command
// codes, tracker geometry and the multiply-detect helper.
package alu_issue_ctrl_pkg;

    // Arithmetic-mode command codes that need a shadow slot
    localparam int unsigned CMD_INC_MUL = 9;
    localparam int unsigned CMD_SHL_MUL = 10;

    // Tracker slot 0 is the op issued on the most recent edge; a
    // non-multiply result is captured from slot 2 (3rd edge after issue),
    // a multiply from slot 3 (4th edge after issue).
    localparam int TRK_DEPTH     = 4;
    localparam int CAP_STAGE_ALU = 2;
    localparam int CAP_STAGE_MUL = 3;

    typedef enum logic {
        ST_ISSUE  = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    function automatic logic is_mul_op(input logic mode, input int unsigned cmd);
        return mode && ((cmd == CMD_INC_MUL) || (cmd == CMD_SHL_MUL));
    endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// dout reads as zero while empty so downstream fields are clean.
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/response-collection stage in front of the ALU core.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_ISSUE  | pop a request (if credit available) or drive a bubble
//   ST_SHADOW | re-drive the multiply just issued, untagged, one cycle
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int OP_WIDTH  = 8,
    parameter int CMD_WIDTH = 4,
    parameter int TAG_WIDTH = 4,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    input  logic                    req_mode,
    input  logic [CMD_WIDTH-1:0]    req_cmd,
    input  logic [1:0]              req_inp_valid,
    input  logic                    req_cin,
    input  logic [OP_WIDTH-1:0]     req_opa,
    input  logic [OP_WIDTH-1:0]     req_opb,
    output logic                    alu_ce,
    output logic [1:0]              alu_inp_valid,
    output logic                    alu_mode,
    output logic [CMD_WIDTH-1:0]    alu_cmd,
    output logic                    alu_cin,
    output logic [OP_WIDTH-1:0]     alu_opa,
    output logic [OP_WIDTH-1:0]     alu_opb,
    input  logic [2*OP_WIDTH-1:0]   alu_res,
    input  logic                    alu_cout,
    input  logic                    alu_oflow,
    input  logic                    alu_g,
    input  logic                    alu_l,
    input  logic                    alu_e,
    input  logic                    alu_err,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [TAG_WIDTH-1:0]    rsp_tag,
    output logic [2*OP_WIDTH-1:0]   rsp_res,
    output logic                    rsp_cout,
    output logic                    rsp_oflow,
    output logic                    rsp_g,
    output logic                    rsp_l,
    output logic                    rsp_e,
    output logic                    rsp_err
);
    localparam int RQ_W  = TAG_WIDTH + 1 + CMD_WIDTH + 2 + 1 + 2*OP_WIDTH;
    localparam int RS_W  = TAG_WIDTH + 2*OP_WIDTH + 6;
    localparam int RQ_CW = $clog2(REQ_DEPTH) + 1;
    localparam int RS_CW = $clog2(RSP_DEPTH) + 1;
    localparam int CR_W  = RS_CW;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic                 mul;
    } trk_t;

    // Request FIFO and decoded head
    logic [RQ_W-1:0]      rq_din;
    logic [RQ_W-1:0]      rq_dout;
    logic [RQ_CW-1:0]     rq_count;
    logic                 rq_push;
    logic                 rq_empty;
    logic [TAG_WIDTH-1:0] hd_tag;
    logic                 hd_mode;
    logic [CMD_WIDTH-1:0] hd_cmd;
    logic [1:0]           hd_inp_valid;
    logic                 hd_cin;
    logic [OP_WIDTH-1:0]  hd_opa;
    logic [OP_WIDTH-1:0]  hd_opb;
    logic                 hd_mul;

    // Issue FSM and ALU input registers
    state_t               state_q, state_d;
    logic                 issue_fire;
    logic [1:0]           inp_valid_d;
    logic                 mode_d;
    logic [CMD_WIDTH-1:0] cmd_d;
    logic                 cin_d;
    logic [OP_WIDTH-1:0]  opa_d;
    logic [OP_WIDTH-1:0]  opb_d;

    // Credits, tracker, response FIFO
    logic [CR_W-1:0]      credit_q, credit_d;
    trk_t                 trk_q [TRK_DEPTH];
    logic                 cap_alu;
    logic                 cap_mul;
    logic [TAG_WIDTH-1:0] cap_tag;
    logic [RS_W-1:0]      rs_din;
    logic [RS_W-1:0]      rs_dout;
    logic [RS_CW-1:0]     rs_count;
    logic                 rs_push;
    logic                 rs_pop;

    assign rq_din    = {req_tag, req_mode, req_cmd, req_inp_valid, req_cin, req_opa, req_opb};
    assign req_ready = !rst && (rq_count != RQ_CW'(REQ_DEPTH));
    assign rq_push   = req_valid && req_ready;
    assign rq_empty  = (rq_count == '0);
    assign {hd_tag, hd_mode, hd_cmd, hd_inp_valid, hd_cin, hd_opa, hd_opb} = rq_dout;
    assign hd_mul    = is_mul_op(hd_mode, 32'(hd_cmd));

    alu_sync_fifo #(
        .WIDTH (RQ_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rq_push),
        .din   (rq_din),
        .pop   (issue_fire),
        .dout  (rq_dout),
        .count (rq_count)
    );

    // Next state and next ALU slot: tagged issue, shadow repeat, or bubble
    always_comb begin
        state_d     = state_q;
        issue_fire  = 1'b0;
        inp_valid_d = '0;
        mode_d      = 1'b0;
        cmd_d       = '0;
        cin_d       = 1'b0;
        opa_d       = '0;
        opb_d       = '0;
        case (state_q)
            ST_ISSUE: begin
                if (!rq_empty && (credit_q != '0)) begin
                    issue_fire  = 1'b1;
                    inp_valid_d = hd_inp_valid;
                    mode_d      = hd_mode;
                    cmd_d       = hd_cmd;
                    cin_d       = hd_cin;
                    opa_d       = hd_opa;
                    opb_d       = hd_opb;
                    if (hd_mul) state_d = ST_SHADOW;
                end
            end
            ST_SHADOW: begin
                inp_valid_d = alu_inp_valid;
                mode_d      = alu_mode;
                cmd_d       = alu_cmd;
                cin_d       = alu_cin;
                opa_d       = alu_opa;
                opb_d       = alu_opb;
                state_d     = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    // FSM state, ALU input registers and clock enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ISSUE;
            alu_ce        <= 1'b0;
            alu_inp_valid <= '0;
            alu_mode      <= 1'b0;
            alu_cmd       <= '0;
            alu_cin       <= 1'b0;
            alu_opa       <= '0;
            alu_opb       <= '0;
        end else begin
            state_q       <= state_d;
            alu_ce        <= 1'b1;
            alu_inp_valid <= inp_valid_d;
            alu_mode      <= mode_d;
            alu_cmd       <= cmd_d;
            alu_cin       <= cin_d;
            alu_opa       <= opa_d;
            alu_opb       <= opb_d;
        end
    end

    // Credit next value: one per tagged issue out, one per response pop back
    always_comb begin
        credit_d = credit_q;
        if (issue_fire && !rs_pop) begin
            credit_d = credit_q - CR_W'(1);
        end else if (!issue_fire && rs_pop) begin
            credit_d = credit_q + CR_W'(1);
        end
    end

    // Credit register, restored to full on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= CR_W'(RSP_DEPTH);
        end else begin
            credit_q <= credit_d;
        end
    end

    // Tracker shift register following each slot through the ALU pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TRK_DEPTH; i++) trk_q[i] <= '0;
        end else begin
            trk_q[0] <= '{valid: issue_fire,
                          tag:   (issue_fire ? hd_tag : '0),
                          mul:   (issue_fire && hd_mul)};
            for (int i = 1; i < TRK_DEPTH; i++) trk_q[i] <= trk_q[i-1];
        end
    end

    // A shadow slot sits between a multiply and the next issue, so the two
    // capture points can never fire on the same edge.
    assign cap_alu = trk_q[CAP_STAGE_ALU].valid && !trk_q[CAP_STAGE_ALU].mul;
    assign cap_mul = trk_q[CAP_STAGE_MUL].valid &&  trk_q[CAP_STAGE_MUL].mul;
    assign cap_tag = cap_mul ? trk_q[CAP_STAGE_MUL].tag : trk_q[CAP_STAGE_ALU].tag;
    assign rs_push = cap_alu || cap_mul;
    assign rs_din  = {cap_tag, alu_res, alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err};

    assign rsp_valid = (rs_count != '0);
    assign rs_pop    = rsp_valid && rsp_ready;
    assign {rsp_tag, rsp_res, rsp_cout, rsp_oflow, rsp_g, rsp_l, rsp_e, rsp_err} = rs_dout;

    alu_sync_fifo #(
        .WIDTH (RS_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rs_push),
        .din   (rs_din),
        .pop   (rs_pop),
        .dout  (rs_dout),
        .count (rs_count)
    );

endmodule
